// File: rtl/fir_decimator_out.sv
// Output stage for the gaussian FIR: drops the pipeline-fill transient, decimates by DECIM,
// and buffers kept samples in a show-ahead FIFO behind a valid/ready handshake.
module fir_decimator_out #(
  parameter int WIDTH  = 8,
  parameter int NCOEFS = 300,
  parameter int DECIM  = 4,
  parameter int DEPTH  = 8
) (
  input  logic                       clock,
  input  logic                       nreset,
  input  logic                       en,
  input  logic [WIDTH-1:0]           xn,
  output logic [WIDTH-1:0]           yn,
  output logic                       yn_valid,
  input  logic                       yn_ready,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  input  logic                       clr_ovf
);

  localparam int AW  = $clog2(DEPTH);
  localparam int LW  = AW + 1;
  localparam int WCW = $clog2(NCOEFS) + 1;
  localparam int PW  = $clog2(DECIM) + 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WARMUP = 2'd1,
    S_RUN    = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WCW-1:0]   warm_q, warm_d;
  logic [PW-1:0]    phase_q, phase_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic keep;
  logic push;
  logic pop;
  logic drop;

  // Sequencer: the cycle en is first seen in IDLE already counts as the first discarded
  // sample, so WARMUP only has to cover the remaining NCOEFS-2 of the fill transient.
  always_comb begin
    // NOTE: every signal gets a default first so no path through the case leaves it
    // unassigned; otherwise synthesis would infer a latch to hold the old value.
    state_d = state_q;
    warm_d  = warm_q;
    phase_d = phase_q;
    keep    = 1'b0;
    if (!en) begin
      state_d = S_IDLE;
      warm_d  = '0;
      phase_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          warm_d  = '0;
          phase_d = '0;
          state_d = (NCOEFS <= 2) ? S_RUN : S_WARMUP;
        end
        S_WARMUP: begin
          warm_d  = warm_q + WCW'(1);
          phase_d = '0;
          if (warm_q + WCW'(1) == WCW'(NCOEFS - 2)) begin
            state_d = S_RUN;
            warm_d  = '0;
          end
        end
        S_RUN: begin
          keep    = (phase_q == '0);
          phase_d = (phase_q == PW'(DECIM - 1)) ? '0 : phase_q + PW'(1);
        end
        default: begin
          state_d = S_IDLE;
          warm_d  = '0;
          phase_d = '0;
        end
      endcase
    end
  end

  // A pop frees a slot in the same cycle, so a full FIFO can still accept a kept sample.
  always_comb begin
    pop      = (level_q != '0) && yn_ready;
    push     = keep && ((level_q != LW'(DEPTH)) || pop);
    drop     = keep && !push;
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q;
    if (push && !pop) level_d = level_q + LW'(1);
    if (pop && !push) level_d = level_q - LW'(1);
    ovf_d    = ovf_q;
    if (clr_ovf) ovf_d = 1'b0;
    if (drop)    ovf_d = 1'b1;
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q  <= S_IDLE;
      warm_q   <= '0;
      phase_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here, so every flop samples the pre-edge values
      // regardless of statement order.
      state_q  <= state_d;
      warm_q   <= warm_d;
      phase_q  <= phase_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end

  // NOTE: the storage is reset because yn is read straight from it and must be 0 after
  // reset; with a handful of entries this costs little.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= xn;
    end
  end

  assign yn       = mem_q[rd_ptr_q];
  assign yn_valid = (level_q != '0);
  assign level    = level_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_fir_decimator_out.sv
// Self-checking bench for fir_decimator_out: directed scenarios plus randomized traffic,
// compared every cycle against a queue-based reference model.
module tb_fir_decimator_out;

  localparam int W  = 8;
  localparam int NC = 4;
  localparam int DC = 3;
  localparam int DP = 4;

  logic         clock = 1'b0;
  logic         nreset = 1'b0;
  logic         en = 1'b0;
  logic [W-1:0] xn = '0;
  logic [W-1:0] yn;
  logic         yn_valid;
  logic         yn_ready = 1'b0;
  logic [2:0]   level;
  logic         overflow;
  logic         clr_ovf = 1'b0;

  fir_decimator_out #(.WIDTH(W), .NCOEFS(NC), .DECIM(DC), .DEPTH(DP)) dut (
    .clock    (clock),
    .nreset   (nreset),
    .en       (en),
    .xn       (xn),
    .yn       (yn),
    .yn_valid (yn_valid),
    .yn_ready (yn_ready),
    .level    (level),
    .overflow (overflow),
    .clr_ovf  (clr_ovf)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: samples since enable, a plain queue for the FIFO, a sticky flag.
  logic [W-1:0] mq[$];
  logic         m_ovf = 1'b0;
  int           run_len = 0;
  logic [W-1:0] popped[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check("yn_valid", {31'b0, yn_valid}, {31'b0, mq.size() != 0});
    check("level", {29'b0, level}, mq.size());
    check("overflow", {31'b0, overflow}, {31'b0, m_ovf});
    if (mq.size() != 0) check("yn", {24'b0, yn}, {24'b0, mq[0]});
  endtask

  task automatic model_clear();
    mq.delete();
    m_ovf   = 1'b0;
    run_len = 0;
  endtask

  task automatic do_reset();
    nreset   = 1'b0;
    en       = 1'b0;
    yn_ready = 1'b0;
    clr_ovf  = 1'b0;
    model_clear();
    repeat (2) @(posedge clock);
    #1;
    check("rst_valid", {31'b0, yn_valid}, 32'd0);
    check("rst_level", {29'b0, level}, 32'd0);
    check("rst_ovf", {31'b0, overflow}, 32'd0);
    check("rst_yn", {24'b0, yn}, 32'd0);
    nreset = 1'b1;
  endtask

  // One clock cycle: drive inputs, predict, clock, compare.
  task automatic step(input logic e, input logic r, input logic c, input logic [W-1:0] x);
    bit keep, pop, push, drop;
    en = e; yn_ready = r; clr_ovf = c; xn = x;
    keep = e && (run_len >= NC - 1) && (((run_len - (NC - 1)) % DC) == 0);
    pop  = (mq.size() != 0) && r;
    push = keep && ((mq.size() < DP) || pop);
    drop = keep && !push;
    if (yn_valid && yn_ready) popped.push_back(yn);
    @(posedge clock);
    #1;
    if (pop)  void'(mq.pop_front());
    if (push) mq.push_back(x);
    if (c)    m_ovf = 1'b0;
    if (drop) m_ovf = 1'b1;
    run_len = e ? run_len + 1 : 0;
    check_outputs();
  endtask

  task automatic check_popped(input string tag, input int exp[$]);
    check({tag, "_npop"}, popped.size(), exp.size());
    for (int j = 0; j < exp.size(); j++)
      if (j < popped.size()) check({tag, "_pop"}, {24'b0, popped[j]}, exp[j]);
  endtask

  initial begin
    int k;
    bit r_bias;

    // 1: free-flowing consumer
    do_reset();
    popped.delete();
    for (int i = 0; i <= 15; i++) step(1, 1, 0, W'(i));
    check_popped("s1", '{3, 6, 9, 12});

    // 2: stalled consumer, overflow on sample 15, then drain
    do_reset();
    for (int i = 0; i <= 16; i++) step(1, 0, 0, W'(i));
    check("s2_level", {29'b0, level}, 32'd4);
    check("s2_ovf", {31'b0, overflow}, 32'd1);
    popped.delete();
    for (int i = 17; i <= 22; i++) step(0, 1, 0, W'(i));
    check_popped("s2", '{3, 6, 9, 12});

    // 3: pop and push together on a full FIFO
    do_reset();
    for (int i = 0; i <= 14; i++) step(1, 0, 0, W'(i));
    popped.delete();
    step(1, 1, 0, W'(15));
    check("s3_level", {29'b0, level}, 32'd4);
    check("s3_ovf", {31'b0, overflow}, 32'd0);
    for (int i = 16; i <= 17; i++) step(1, 0, 0, W'(i));
    for (int i = 18; i <= 23; i++) step(0, 1, 0, W'(i));
    check_popped("s3", '{3, 6, 9, 12, 15});

    // 4: enable dropped after 6 stored, re-raised 5 cycles later
    do_reset();
    popped.delete();
    for (int i = 0; i <= 6; i++) step(1, 0, 0, W'(i));
    for (int i = 7; i <= 11; i++) step(0, 1, 0, W'(i));
    k = 12;
    for (int i = k; i <= k + 4; i++) step(1, 1, 0, W'(i));
    check_popped("s4", '{3, 6, k + 3});

    // 5: asynchronous reset mid-cycle with level 3
    do_reset();
    for (int i = 0; i <= 9; i++) step(1, 0, 0, W'(i));
    check("s5_level_pre", {29'b0, level}, 32'd3);
    #3;
    nreset = 1'b0;
    #1;
    check("s5_valid", {31'b0, yn_valid}, 32'd0);
    check("s5_level", {29'b0, level}, 32'd0);
    check("s5_ovf", {31'b0, overflow}, 32'd0);
    do_reset();
    for (int i = 0; i <= 3; i++) step(1, 1, 0, W'(100 + i));
    check("s5_restart", {24'b0, yn}, 32'd103);

    // 6: clear versus set of the sticky overflow
    do_reset();
    for (int i = 0; i <= 17; i++) step(1, 0, 0, W'(i));
    check("s6_ovf_set", {31'b0, overflow}, 32'd1);
    step(1, 0, 1, W'(18));
    check("s6_ovf_drop_clr", {31'b0, overflow}, 32'd1);
    step(1, 0, 1, W'(19));
    check("s6_ovf_clr", {31'b0, overflow}, 32'd0);

    // Randomized traffic with bursty consumer behaviour
    do_reset();
    r_bias = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (i % 150 == 0) r_bias = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 799) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 15) != 0,
             r_bias ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0),
             $urandom_range(0, 19) == 0,
             W'($urandom));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
